// File: rtl/rv32i_types.sv
// Shared types for the decode stage: ALU op codes, opcodes, funct fields,
// operand selectors and the ID/EX pipeline register layout.
package rv32i_types;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    alu_add = 3'd0,
    alu_sll = 3'd1,
    alu_sra = 3'd2,
    alu_sub = 3'd3,
    alu_xor = 3'd4,
    alu_srl = 3'd5,
    alu_or  = 3'd6,
    alu_and = 3'd7
  } alu_ops_t;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } opcode_t;

  localparam logic [2:0] f3_add  = 3'b000;
  localparam logic [2:0] f3_sll  = 3'b001;
  localparam logic [2:0] f3_slt  = 3'b010;
  localparam logic [2:0] f3_sltu = 3'b011;
  localparam logic [2:0] f3_xor  = 3'b100;
  localparam logic [2:0] f3_sr   = 3'b101;
  localparam logic [2:0] f3_or   = 3'b110;
  localparam logic [2:0] f3_and  = 3'b111;

  localparam logic [6:0] f7_base = 7'b0000000;
  localparam logic [6:0] f7_alt  = 7'b0100000;

  typedef enum logic [1:0] {
    a_zero = 2'd0,
    a_rs1  = 2'd1,
    a_pc   = 2'd2
  } a_sel_t;

  typedef enum logic [1:0] {
    b_zero = 2'd0,
    b_rs2  = 2'd1,
    b_imm  = 2'd2
  } b_sel_t;

  typedef struct packed {
    alu_ops_t    aluop;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
    logic [31:0] pc;
  } id_ex_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I decoder: turns an instruction word into the ALU op,
// operand source selects, immediate and writeback/illegal flags.
module alu_decoder
  import rv32i_types::*;
(
  input  logic [31:0] instr,
  output alu_ops_t    aluop,
  output a_sel_t      a_sel,
  output b_sel_t      b_sel,
  output logic [31:0] imm,
  output logic        we,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       unused_rs1;

  assign opcode     = instr[6:0];
  assign funct3     = instr[14:12];
  assign funct7     = instr[31:25];
  assign rd         = instr[11:7];
  assign unused_rs1 = ^instr[19:15];

  // Classify the opcode, pick the ALU op and operand sources; anything not
  // recognised collapses to a harmless add of zeros flagged illegal.
  always_comb begin
    aluop   = alu_add;
    a_sel   = a_zero;
    b_sel   = b_zero;
    imm     = '0;
    illegal = 1'b0;
    case (opcode)
      op_reg: begin
        a_sel = a_rs1;
        b_sel = b_rs2;
        case (funct3)
          f3_add: begin
            if (funct7 == f7_base)     aluop = alu_add;
            else if (funct7 == f7_alt) aluop = alu_sub;
            else                       illegal = 1'b1;
          end
          f3_sll: begin
            if (funct7 == f7_base) aluop = alu_sll;
            else                   illegal = 1'b1;
          end
          f3_xor: begin
            if (funct7 == f7_base) aluop = alu_xor;
            else                   illegal = 1'b1;
          end
          f3_sr: begin
            if (funct7 == f7_base)     aluop = alu_srl;
            else if (funct7 == f7_alt) aluop = alu_sra;
            else                       illegal = 1'b1;
          end
          f3_or: begin
            if (funct7 == f7_base) aluop = alu_or;
            else                   illegal = 1'b1;
          end
          f3_and: begin
            if (funct7 == f7_base) aluop = alu_and;
            else                   illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      op_imm: begin
        a_sel = a_rs1;
        b_sel = b_imm;
        imm   = imm_i(instr);
        case (funct3)
          f3_add: aluop = alu_add;
          f3_sll: begin
            if (funct7 == f7_base) aluop = alu_sll;
            else                   illegal = 1'b1;
          end
          f3_xor: aluop = alu_xor;
          f3_sr: begin
            if (funct7 == f7_base)     aluop = alu_srl;
            else if (funct7 == f7_alt) aluop = alu_sra;
            else                       illegal = 1'b1;
          end
          f3_or:  aluop = alu_or;
          f3_and: aluop = alu_and;
          default: illegal = 1'b1;
        endcase
      end
      op_lui: begin
        a_sel = a_zero;
        b_sel = b_imm;
        imm   = imm_u(instr);
      end
      op_auipc: begin
        a_sel = a_pc;
        b_sel = b_imm;
        imm   = imm_u(instr);
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      aluop = alu_add;
      a_sel = a_zero;
      b_sel = b_zero;
      imm   = '0;
    end
  end

  assign we = !illegal && (rd != 5'd0);

endmodule

// File: rtl/id_alu_stage.sv
// Decode stage feeding the ALU: accepts instructions over valid/ready, reads
// the register file combinationally and holds the decoded result in an
// ID/EX register with stall and flush handling.
module id_alu_stage
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_rdata,
  input  logic [XLEN-1:0] rs2_rdata,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [2:0]      ex_aluop,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic            ex_illegal,
  output logic [XLEN-1:0] ex_pc
);

  alu_ops_t    dec_aluop;
  a_sel_t      dec_a_sel;
  b_sel_t      dec_b_sel;
  logic [31:0] dec_imm;
  logic        dec_we;
  logic        dec_illegal;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        load;
  id_ex_t      dec_next;
  id_ex_t      ex_q;

  assign rs1_addr = id_instr[19:15];
  assign rs2_addr = id_instr[24:20];

  // x0 always reads as zero regardless of what the register file returns.
  assign rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_rdata;
  assign rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_rdata;

  // A held instruction that is not being consumed blocks the input unless
  // a flush is about to squash it anyway.
  assign id_ready = !ex_valid || ex_ready || flush;
  assign load     = id_valid && id_ready && !flush;

  alu_decoder u_dec (
    .instr   (id_instr),
    .aluop   (dec_aluop),
    .a_sel   (dec_a_sel),
    .b_sel   (dec_b_sel),
    .imm     (dec_imm),
    .we      (dec_we),
    .illegal (dec_illegal)
  );

  // Assemble the next ID/EX contents from the decoder selects.
  always_comb begin
    dec_next         = '0;
    dec_next.aluop   = dec_aluop;
    dec_next.rd      = id_instr[11:7];
    dec_next.we      = dec_we;
    dec_next.illegal = dec_illegal;
    dec_next.pc      = id_pc;
    case (dec_a_sel)
      a_rs1:   dec_next.a = rs1_val;
      a_pc:    dec_next.a = id_pc;
      default: dec_next.a = '0;
    endcase
    case (dec_b_sel)
      b_rs2:   dec_next.b = rs2_val;
      b_imm:   dec_next.b = dec_imm;
      default: dec_next.b = '0;
    endcase
  end

  // ID/EX register: flush beats load, load beats drain, otherwise stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid <= 1'b1;
      ex_q     <= dec_next;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_aluop   = ex_q.aluop;
  assign ex_a       = ex_q.a;
  assign ex_b       = ex_q.b;
  assign ex_rd      = ex_q.rd;
  assign ex_we      = ex_q.we;
  assign ex_illegal = ex_q.illegal;
  assign ex_pc      = ex_q.pc;

endmodule
